// File: rtl/int_ctrl.sv
// int_ctrl -- prioritised interrupt controller.
//
// Latches NR_CHAN device request lines and applies a CPU-programmable mask.
// Presents the lowest-numbered pending, enabled channel to the CPU.
// Returns one-cycle acknowledge pulses when the CPU writes the ACK register.
//
// Optional feature: define INT_CTRL_EDGE_EN to build the MODE register and
// per-channel rising-edge detection. Without it every channel is level
// sensitive, MODE reads 0 and MODE writes are ignored.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   dev_req       device request lines, bit i = channel i
//   dev_ack       one-cycle acknowledge pulse per channel
//   cpu_int_req   registered, high while any enabled channel is pending
//   cpu_int_id    registered, lowest pending enabled channel (0 if none)
//   reg_sel       register access strobe (one cycle per access)
//   reg_is_write  1 = write, 0 = read
//   reg_addr      0 PENDING, 1 MASK, 2 ACK, 3 MODE
//   reg_data_in   write data, bits at and above NR_CHAN ignored
//   reg_data_out  read data, held until the next read
module int_ctrl #(
  parameter int NR_CHAN  = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NR_CHAN-1:0]  dev_req,
  output logic [NR_CHAN-1:0]  dev_ack,
  output logic                cpu_int_req,
  output logic [ID_WIDTH-1:0] cpu_int_id,
  input  logic                reg_sel,
  input  logic                reg_is_write,
  input  logic [1:0]          reg_addr,
  input  logic [31:0]         reg_data_in,
  output logic [31:0]         reg_data_out
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_ACK     = 2'd2;
  localparam logic [1:0] ADDR_MODE    = 2'd3;

  logic                wr_en;
  logic                rd_en;
  logic [NR_CHAN-1:0]  wdata;
  logic [NR_CHAN-1:0]  ack_bits;
  logic                unused_wdata;

  logic [NR_CHAN-1:0]  req_q;
  logic [NR_CHAN-1:0]  ack_wait_q, ack_wait_d;
  logic [NR_CHAN-1:0]  mask_q, mask_d;
  logic [NR_CHAN-1:0]  dev_ack_q;
  logic                cpu_int_req_q, cpu_int_req_d;
  logic [ID_WIDTH-1:0] cpu_int_id_q, cpu_int_id_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NR_CHAN-1:0]  pending;
  logic [NR_CHAN-1:0]  active;
  logic [NR_CHAN-1:0]  mode_v;    // current per-channel mode, 1 = edge
  logic [NR_CHAN-1:0]  mode_chg;  // channels whose mode flips this cycle

  assign wr_en        = reg_sel & reg_is_write;
  assign rd_en        = reg_sel & ~reg_is_write;
  assign wdata        = reg_data_in[NR_CHAN-1:0];
  assign unused_wdata = ^reg_data_in[31:NR_CHAN];
  assign ack_bits     = (wr_en && reg_addr == ADDR_ACK) ? wdata : '0;
  assign mask_d       = (wr_en && reg_addr == ADDR_MASK) ? wdata : mask_q;

`ifdef INT_CTRL_EDGE_EN
  logic [NR_CHAN-1:0] req_qq;
  logic [NR_CHAN-1:0] mode_q, mode_d;
  logic [NR_CHAN-1:0] edge_pend_q, edge_pend_d;

  assign mode_d   = (wr_en && reg_addr == ADDR_MODE) ? wdata : mode_q;
  assign mode_chg = mode_d ^ mode_q;
  assign mode_v   = mode_q;
`else
  assign mode_chg = '0;
  assign mode_v   = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NR_CHAN; gi++) begin : g_chan
`ifdef INT_CTRL_EDGE_EN
      // Rising edge is OR-ed in after the ACK clear so a simultaneous edge
      // is never lost; a mode change discards stale state.
      assign edge_pend_d[gi] = mode_chg[gi] ? 1'b0 :
          ((edge_pend_q[gi] & ~ack_bits[gi]) | (req_q[gi] & ~req_qq[gi]));
      assign pending[gi] = mode_q[gi] ? edge_pend_q[gi]
                                      : (req_q[gi] & ~ack_wait_q[gi]);
`else
      assign pending[gi] = req_q[gi] & ~ack_wait_q[gi];
`endif
      // ack_wait masks a level request until the device drops it; the clear
      // happens on the edge where req_q takes the 0.
      assign ack_wait_d[gi] = (mode_chg[gi] | mode_v[gi]) ? 1'b0 :
                              ack_bits[gi] ? 1'b1 :
                              (ack_wait_q[gi] & dev_req[gi]);
    end
  endgenerate

  // Fixed priority, channel 0 highest: scan downward so the lowest index wins.
  always_comb begin
    active        = pending & mask_q;
    cpu_int_req_d = |active;
    cpu_int_id_d  = '0;
    for (int i = NR_CHAN - 1; i >= 0; i--) begin
      if (active[i]) cpu_int_id_d = ID_WIDTH'(i);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (reg_addr)
        ADDR_PENDING: rdata_d[NR_CHAN-1:0] = pending;
        ADDR_MASK:    rdata_d[NR_CHAN-1:0] = mask_q;
        ADDR_MODE:    rdata_d[NR_CHAN-1:0] = mode_v;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      ack_wait_q    <= '0;
      mask_q        <= '0;
      dev_ack_q     <= '0;
      cpu_int_req_q <= 1'b0;
      cpu_int_id_q  <= '0;
      rdata_q       <= '0;
    end else begin
      req_q         <= dev_req;
      ack_wait_q    <= ack_wait_d;
      mask_q        <= mask_d;
      dev_ack_q     <= ack_bits;
      cpu_int_req_q <= cpu_int_req_d;
      cpu_int_id_q  <= cpu_int_id_d;
      rdata_q       <= rdata_d;
    end
  end

`ifdef INT_CTRL_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      req_qq      <= '0;
      mode_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      req_qq      <= req_q;
      mode_q      <= mode_d;
      edge_pend_q <= edge_pend_d;
    end
  end
`endif

  assign dev_ack      = dev_ack_q;
  assign cpu_int_req  = cpu_int_req_q;
  assign cpu_int_id   = cpu_int_id_q;
  assign reg_data_out = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl. Each clock edge the stimulus side advances
// a behavioural model of the controller and queues the outputs it expects
// after that edge; a monitor on the falling edge pops and compares.
module tb_int_ctrl;

  localparam int NR_CHAN  = 4;
  localparam int ID_WIDTH = 4;
`ifdef INT_CTRL_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NR_CHAN-1:0]  dev_req;
  logic [NR_CHAN-1:0]  dev_ack;
  logic                cpu_int_req;
  logic [ID_WIDTH-1:0] cpu_int_id;
  logic                reg_sel;
  logic                reg_is_write;
  logic [1:0]          reg_addr;
  logic [31:0]         reg_data_in;
  logic [31:0]         reg_data_out;

  int_ctrl #(.NR_CHAN(NR_CHAN), .ID_WIDTH(ID_WIDTH)) dut (
    .clk(clk), .rst(rst), .dev_req(dev_req), .dev_ack(dev_ack),
    .cpu_int_req(cpu_int_req), .cpu_int_id(cpu_int_id),
    .reg_sel(reg_sel), .reg_is_write(reg_is_write), .reg_addr(reg_addr),
    .reg_data_in(reg_data_in), .reg_data_out(reg_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR_CHAN-1:0]  ack;
    logic                irq;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: what the device has seen, what each channel owes
  // the CPU, and what the CPU has programmed.
  bit          seen_req [NR_CHAN];   // request as latched last edge
  bit          seen_prev[NR_CHAN];   // request latched the edge before
  bit          edge_flag[NR_CHAN];   // edge channel: remembered rising edge
  bit          acked    [NR_CHAN];   // level channel: acked, waiting for drop
  bit          en       [NR_CHAN];
  bit          edge_mode[NR_CHAN];
  logic [31:0] last_read;

  function automatic bit owes(int ch);
    if (edge_mode[ch]) return edge_flag[ch];
    return seen_req[ch] && !acked[ch];
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   is_wr, is_rd;
    e = '0;
    is_wr = reg_sel && reg_is_write;
    is_rd = reg_sel && !reg_is_write;
    if (rst) begin
      for (int ch = 0; ch < NR_CHAN; ch++) begin
        seen_req[ch] = 0; seen_prev[ch] = 0; edge_flag[ch] = 0;
        acked[ch] = 0; en[ch] = 0; edge_mode[ch] = 0;
      end
      last_read = 0;
    end else begin
      // CPU view reflects the state before this edge.
      for (int ch = NR_CHAN - 1; ch >= 0; ch--) begin
        if (owes(ch) && en[ch]) begin
          e.irq = 1'b1;
          e.id  = ID_WIDTH'(ch);
        end
      end
      if (is_rd) begin
        last_read = 0;
        for (int ch = 0; ch < NR_CHAN; ch++) begin
          case (reg_addr)
            2'd0: last_read[ch] = owes(ch);
            2'd1: last_read[ch] = en[ch];
            2'd3: last_read[ch] = edge_mode[ch];
            default: last_read[ch] = 1'b0;
          endcase
        end
      end
      for (int ch = 0; ch < NR_CHAN; ch++) begin
        bit ack_now, rise, new_mode;
        ack_now  = is_wr && reg_addr == 2'd2 && reg_data_in[ch];
        rise     = seen_req[ch] && !seen_prev[ch];
        new_mode = (is_wr && reg_addr == 2'd3 && EDGE_EN) ? reg_data_in[ch]
                                                          : edge_mode[ch];
        e.ack[ch] = ack_now;
        if (new_mode != edge_mode[ch]) begin
          edge_flag[ch] = 0;
          acked[ch]     = 0;
        end else if (edge_mode[ch]) begin
          if (ack_now) edge_flag[ch] = 0;
          if (rise)    edge_flag[ch] = 1;
        end else begin
          if (ack_now)          acked[ch] = 1;
          else if (!dev_req[ch]) acked[ch] = 0;
        end
        edge_mode[ch] = new_mode;
        if (is_wr && reg_addr == 2'd1) en[ch] = reg_data_in[ch];
        seen_prev[ch] = seen_req[ch];
        seen_req[ch]  = dev_req[ch];
      end
    end
    e.rdata = last_read;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dev_ack",      32'(dev_ack),     32'(e.ack));
      chk("cpu_int_req",  32'(cpu_int_req), 32'(e.irq));
      chk("cpu_int_id",   32'(cpu_int_id),  32'(e.id));
      chk("reg_data_out", reg_data_out,     e.rdata);
    end
  end

  task automatic step(input logic [NR_CHAN-1:0] req, input logic sel, input logic wr,
                      input logic [1:0] addr, input logic [31:0] data, input logic r);
    dev_req      = req;
    reg_sel      = sel;
    reg_is_write = wr;
    reg_addr     = addr;
    reg_data_in  = data;
    rst          = r;
    if (sel) $display("txn t=%0t %s addr=%0d data=%h req=%h rst=%0d",
                      $time, wr ? "WR" : "RD", addr, data, req, r);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [NR_CHAN-1:0] req, input int n);
    for (int k = 0; k < n; k++) step(req, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic reg_wr(input logic [1:0] addr, input logic [31:0] data,
                        input logic [NR_CHAN-1:0] req);
    step(req, 1'b1, 1'b1, addr, data, 1'b0);
  endtask

  task automatic reg_rd(input logic [1:0] addr, input logic [NR_CHAN-1:0] req);
    step(req, 1'b1, 1'b0, addr, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    step('0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [NR_CHAN-1:0] rq;
    last_read = 0;
    dev_req = '0; reg_sel = 0; reg_is_write = 0; reg_addr = 0; reg_data_in = 0; rst = 1;
    #1;
    do_reset();
    reg_rd(2'd1, 4'h0);            // reset MASK reads 0

    // Level basic: ACK while the device still holds its request.
    reg_wr(2'd1, 32'hF, 4'h0);
    idle(4'h4, 3);
    reg_wr(2'd2, 32'h4, 4'h4);
    idle(4'h4, 3);
    idle(4'h0, 3);

    // Priority and mask.
    do_reset();
    idle(4'hA, 2);
    reg_wr(2'd1, 32'h8, 4'hA);
    idle(4'hA, 2);
    reg_wr(2'd1, 32'hFFFF_FFFF, 4'hA);
    idle(4'hA, 2);
    reg_rd(2'd0, 4'hA);
    idle(4'h0, 2);

    // Masked pending stays visible.
    do_reset();
    idle(4'h2, 3);
    reg_rd(2'd0, 4'h2);
    reg_wr(2'd1, 32'h2, 4'h2);
    idle(4'h2, 3);

    // Edge mode (MODE ignored when the feature is not built).
    do_reset();
    reg_wr(2'd1, 32'hF, 4'h0);
    reg_wr(2'd3, 32'h1, 4'h0);
    reg_rd(2'd3, 4'h0);
    idle(4'h1, 1);
    idle(4'h0, 4);
    reg_rd(2'd0, 4'h0);
    idle(4'h1, 1);
    reg_wr(2'd2, 32'h1, 4'h1);     // ACK on the edge the rising edge is seen
    idle(4'h1, 3);
    reg_rd(2'd0, 4'h1);
    reg_wr(2'd3, 32'h0, 4'h0);     // mode change clears channel state
    idle(4'h0, 3);

    // Reset mid-operation with an ACK in the same cycle.
    reg_wr(2'd1, 32'hF, 4'h3);
    idle(4'h3, 3);
    step(4'h3, 1'b1, 1'b1, 2'd2, 32'h3, 1'b1);
    idle(4'h3, 1);
    reg_rd(2'd1, 4'h3);
    idle(4'h0, 2);

    // Randomised traffic.
    rq = '0;
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < NR_CHAN; b++)
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      if ($urandom_range(99) < 3) begin
        step(rq, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
      end else if ($urandom_range(99) < 35) begin
        step(rq, 1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, 1'b0);
      end else begin
        idle(rq, 1);
      end
    end
    idle(4'h0, 2);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller between the peripheral devices (serial port, keyboard, future timer/DMA) and the CPU. It replaces point-to-point interrupt wiring with one block. The block latches up to NR_CHAN device request lines, applies a CPU-programmable mask, and presents a single prioritised interrupt plus channel ID to the CPU. It returns per-channel acknowledge pulses to devices when the CPU writes the ACK register over a small register port driven by the physical memory controller.

## Interface
- NR_CHAN, 4: number of request channels, legal 1..16.
- ID_WIDTH, 4: width of cpu_int_id; must satisfy 2^ID_WIDTH >= NR_CHAN.
- clk  input  1  system clock; the only clock of the block.
- rst  input  1  reset; synchronous, active-high.
- dev_req  input  NR_CHAN  device request lines, asynchronous to nothing (already in clk domain), bit i = channel i.
- dev_ack  output  NR_CHAN  one-cycle acknowledge pulse per channel.
- cpu_int_req  output  1  registered; high while any unmasked channel is pending.
- cpu_int_id  output  ID_WIDTH  registered; lowest-numbered pending unmasked channel, 0 when cpu_int_req low.
- reg_sel  input  1  register access strobe, one cycle per access.
- reg_is_write  input  1  1 = write, 0 = read (qualified by reg_sel).
- reg_addr  input  2  register select: 0 PENDING, 1 MASK, 2 ACK, 3 MODE.
- reg_data_in  input  32  write data; bits above NR_CHAN ignored.
- reg_data_out  output  32  read data; bits above NR_CHAN read 0.

## Operation
- Per channel state: req_q (sampled dev_req), req_qq (previous sample), pending, ack_wait, mask bit, mode bit (0 level, 1 edge).
- Level channel: pending = req_q & ~ack_wait. ACK write of bit i sets ack_wait[i]. ack_wait[i] clears on the first cycle req_q[i] samples 0. This prevents re-triggering while the device is still dropping its request.
- Edge channel: pending[i] sets on req_q & ~req_qq, and clears on ACK write of bit i. If a rising edge and an ACK land in the same cycle, set wins and no edge is lost. ack_wait is unused.
- ACK write: for every 1 bit, dev_ack[i] pulses high for exactly one cycle, in both modes, whether or not the channel was pending. 0 bits have no effect.
- MASK: 1 = enabled. Masked channels still latch pending and are visible in PENDING. They never drive cpu_int_req.
- Priority: fixed, channel 0 highest. cpu_int_id = index of lowest set bit of pending & mask.
- Reads: PENDING returns pending. MASK and MODE return register contents. ACK reads 0.
- Writes to PENDING are ignored. A write to MODE that changes a channel's mode clears that channel's pending and ack_wait.
- reg_sel with a read and a write in the same cycle cannot occur, because reg_is_write selects one.

## Timing
- Reset values: dev_ack 0, cpu_int_req 0, cpu_int_id 0, reg_data_out 0, mask 0 (all disabled), mode 0, pending/ack_wait/req_q/req_qq 0.
- dev_req rising before edge t: req_q = 1 after edge t; pending after edge t (level) or t+1 (edge mode, which sets its pending flop at t+1); cpu_int_req high after edge t+1 (level) or t+2 (edge).
- ACK write sampled at edge t: dev_ack pulse high for the cycle after edge t. pending/ack_wait update at edge t. cpu_int_req and cpu_int_id reflect the update after edge t+1.
- MASK write at edge t: cpu_int_req reflects the new mask after edge t+1.
- Read sampled at edge t: reg_data_out valid after edge t and held until the next read.
- rst asserted mid-operation: all state returns to reset values on that edge. A dev_ack pulse in flight is truncated to 0.

## Configuration
- INT_CTRL_EDGE_EN defined: MODE register implemented as above, and per-channel edge detection is present.
- INT_CTRL_EDGE_EN undefined: all channels are level mode. MODE reads 0 and writes are ignored. req_qq and the edge logic are not built.

## Test plan
- Level basic: NR_CHAN=4, mask=0xF, raise dev_req[2] -> cpu_int_req=1, cpu_int_id=2 two cycles later. Write ACK=0x4 -> dev_ack=0x4 for one cycle. Device holds req 3 more cycles then drops -> cpu_int_req stays 0 throughout.
- Priority/mask: dev_req=0b1010, mask=0b1000 -> cpu_int_id=3. Write mask=0xF -> cpu_int_id=1 one cycle after the write. Read PENDING -> 0x0000000A.
- Edge mode (INT_CTRL_EDGE_EN): MODE=0x1, pulse dev_req[0] one cycle -> pending[0]=1 persists. ACK in the same cycle as a second rising edge -> pending[0] remains 1.
- Masked pending: mask=0, dev_req[1]=1 -> cpu_int_req=0, PENDING=0x2. Enabling mask bit 1 -> cpu_int_req=1 after one cycle.
- Reset mid-operation: pending=0x3, mask=0xF, ACK write and rst in the same cycle -> next cycle all outputs 0, MASK reads 0.
- Macro off: write MODE=0xF, read MODE -> 0. A one-cycle pulse on dev_req[0] is not latched after it drops (level behaviour).
